rdiv_share_arbiter: RTL and testbench
=====================================

Name: rdiv_share_arbiter

Overview:
Shares one rounding-divide-by-2^DIV_LOG2 datapath among NUM_REQ requesters. Requesters are served in round-robin order. The block captures one operand at a time, computes the rounded-half-up, saturated quotient, and returns it with the requester ID over a valid/ready response port. It sits between several fixed-point producers (e.g. accumulator drains) and a single downstream consumer.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DIV_LOG2, 3, divide by 2^DIV_LOG2 (≥1)
OUT_WIDTH, 8, quotient width
IN_WIDTH, OUT_WIDTH+DIV_LOG2, operand width
ID_W, $clog2(NUM_REQ), requester ID width
CNT_W, 16, saturation counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit set (one-hot)
req_din  input  NUM_REQ*IN_WIDTH  operands; requester i occupies bits [i*IN_WIDTH +: IN_WIDTH]
resp_valid  output  1  result valid
resp_ready  input  1  consumer accept
resp_dout  output  OUT_WIDTH  rounded quotient
resp_id  output  ID_W  index of the served requester
resp_sat  output  1  result was saturated
sat_count  output  CNT_W  total saturated results since reset

Behaviour:
- Reset (rst=0, async): state=IDLE, rr pointer=0, req_ready=0, resp_valid=0, resp_dout=0, resp_id=0, resp_sat=0, sat_count=0. Reset mid-transaction discards any captured operand or pending result; no response is emitted for it.
- FSM states: IDLE, CALC, RESP.
- IDLE: arbitration is combinational.
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - The winner is the first i with req_valid[i]=1. req_ready[winner]=1; all other bits are 0.
  - req_ready may depend combinationally on req_valid.
  - On handshake: capture operand and ID, set ptr=(winner+1) mod NUM_REQ, go to CALC.
  - With no valid request, stay in IDLE and keep ptr unchanged.
- CALC (1 cycle): req_ready=0.
  - q = din >> DIV_LOG2, computed at OUT_WIDTH+1 bits.
  - Add 1 if din[DIV_LOG2-1]=1 (round half up: remainder ≥ 2^(DIV_LOG2-1) rounds up).
  - If the sum is ≥ 2^OUT_WIDTH, or any of din[IN_WIDTH-1:OUT_WIDTH+DIV_LOG2] is set (only when IN_WIDTH is overridden wider), then resp_dout = all ones and resp_sat=1. Otherwise resp_dout = sum[OUT_WIDTH-1:0] and resp_sat=0.
  - Register the outputs and go to RESP.
  - If resp_sat=1, sat_count increments, saturating at all ones (no wrap).
- RESP: resp_valid=1. resp_dout, resp_id and resp_sat are held stable until resp_ready=1. On that cycle the handshake completes and the FSM goes to IDLE. resp_valid drops the next cycle unless reset intervenes.
- Latency: request handshake in cycle t gives resp_valid in cycle t+2. Minimum issue interval is 3 cycles with resp_ready held at 1.
- Outside IDLE, req_ready=0 for all requesters. Requesters must hold req_valid and req_din until they are accepted.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Simultaneous requests: only one is accepted per IDLE cycle; the others stay pending.
- Backpressure: resp_ready low stalls in RESP indefinitely; no operand is accepted while stalled.

Test Plan:
1. Defaults. Requester 0 sends din=73 → resp_dout=9, resp_sat=0, resp_id=0, resp_valid at handshake+2 cycles.
2. Requester 2 sends din=79 → resp_dout=10 (round up). din=76 (remainder 4) → 10. din=75 → 9.
3. Saturation boundary:
   - din=2043 → 255, sat=0.
   - din=2044 → 255, sat=1.
   - din=2047 → 255, sat=1.
   - sat_count reads 2 after these three.
4. Round robin: all four req_valid held high from reset, resp_ready=1 → resp_id sequence 0,1,2,3,0. Each requester is granted exactly once per 4 grants, and req_ready is never multi-hot.
5. Backpressure: hold resp_ready=0 for 10 cycles in RESP.
   - resp_valid stays 1 and outputs stay stable.
   - req_ready stays all-zero.
   - Releasing resp_ready completes exactly one response, then the next grant follows.
6. Drop rst to 0 asynchronously while in CALC and again while in RESP → all outputs go to 0 immediately. After release, the next grant goes to requester 0 and no stale response appears.

Source files
------------

// File: rtl/rdiv_share_arbiter.sv
// Shares one rounding, saturating divide-by-2^DIV_LOG2 datapath among NUM_REQ
// requesters served round-robin; results return with the requester ID over valid/ready.
module rdiv_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DIV_LOG2  = 3,
    parameter int OUT_WIDTH = 8,
    parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*IN_WIDTH-1:0] req_din,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [OUT_WIDTH-1:0]        resp_dout,
    output logic [ID_W-1:0]             resp_id,
    output logic                        resp_sat,
    output logic [CNT_W-1:0]            sat_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        ptr_d;
    logic [ID_W-1:0]        win_s;
    logic                   found_s;
    logic                   hs_req_s;
    logic [NUM_REQ-1:0]     req_ready_s;
    logic [IN_WIDTH-1:0]    sel_din_s;
    logic [IN_WIDTH-1:0]    din_q;
    logic [OUT_WIDTH:0]     calc_s;
    logic [OUT_WIDTH-1:0]   resp_dout_q;
    logic [ID_W-1:0]        resp_id_q;
    logic                   resp_valid_q;
    logic                   resp_sat_q;
    logic [CNT_W-1:0]       sat_count_q;

    // Returns {sat, quotient}: round half up, clamp to all ones on overflow.
    function automatic logic [OUT_WIDTH:0] rdiv_calc(input logic [IN_WIDTH-1:0] din);
        logic [OUT_WIDTH:0] sum;
        logic               hi;
        sum = {1'b0, din[OUT_WIDTH+DIV_LOG2-1:DIV_LOG2]}
            + {{OUT_WIDTH{1'b0}}, din[DIV_LOG2-1]};
        hi  = |(din >> (OUT_WIDTH + DIV_LOG2));
        if (sum[OUT_WIDTH] || hi) begin
            rdiv_calc = {1'b1, {OUT_WIDTH{1'b1}}};
        end else begin
            rdiv_calc = {1'b0, sum[OUT_WIDTH-1:0]};
        end
    endfunction

    // First valid requester at or after ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int   idx;
        logic take;
        win_s   = '0;
        found_s = 1'b0;
        idx     = 0;
        take    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx     = (int'(ptr_q) + k >= NUM_REQ) ? int'(ptr_q) + k - NUM_REQ : int'(ptr_q) + k;
            take    = !found_s && req_valid[ID_W'(idx)];
            win_s   = take ? ID_W'(idx) : win_s;
            found_s = found_s | take;
        end
    end

    // Operand of the current winner.
    always_comb begin
        sel_din_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_din_s = (ID_W'(i) == win_s) ? req_din[i*IN_WIDTH +: IN_WIDTH] : sel_din_s;
        end
    end

    // Grant is masked while reset is asserted so req_ready reads zero during reset.
    assign req_ready_s = (state_q == ST_IDLE && found_s && rst)
                       ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_s) : '0;
    assign hs_req_s    = |(req_valid & req_ready_s);
    assign ptr_d       = (win_s == ID_W'(NUM_REQ - 1)) ? '0 : win_s + ID_W'(1);
    assign calc_s      = rdiv_calc(din_q);

    // Control FSM with registered response outputs and saturation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            din_q        <= '0;
            resp_dout_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_sat_q   <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_req_s) begin
                        din_q     <= sel_din_s;
                        resp_id_q <= win_s;
                        ptr_q     <= ptr_d;
                        state_q   <= ST_CALC;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    resp_sat_q   <= calc_s[OUT_WIDTH];
                    resp_dout_q  <= calc_s[OUT_WIDTH-1:0];
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                    if (calc_s[OUT_WIDTH] && sat_count_q != {CNT_W{1'b1}}) begin
                        sat_count_q <= sat_count_q + CNT_W'(1);
                    end else begin
                        sat_count_q <= sat_count_q;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q      <= ST_RESP;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_q;
    assign resp_dout  = resp_dout_q;
    assign resp_id    = resp_id_q;
    assign resp_sat   = resp_sat_q;
    assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_rdiv_share_arbiter.sv
// Self-checking bench for rdiv_share_arbiter: directed steps plus randomized
// transactions compared against an arithmetic reference model.
module tb_rdiv_share_arbiter;
    localparam int NR = 4;
    localparam int DL = 3;
    localparam int OW = 8;
    localparam int IW = OW + DL;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*IW-1:0]  req_din;
    logic              resp_valid;
    logic              resp_ready;
    logic [OW-1:0]     resp_dout;
    logic [1:0]        resp_id;
    logic              resp_sat;
    logic [15:0]       sat_count;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;
    int sat_m  = 0;
    logic [IW-1:0] din_v [NR];

    rdiv_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_din(req_din),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dout(resp_dout),
        .resp_id(resp_id), .resp_sat(resp_sat), .sat_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Quotient rounded half up, clamped to OW bits.
    function automatic int ref_q(input int din);
        int q;
        q = (din + (1 << (DL - 1))) >> DL;
        return (q > (1 << OW) - 1) ? (1 << OW) - 1 : q;
    endfunction

    function automatic int ref_sat(input int din);
        return (((din + (1 << (DL - 1))) >> DL) > (1 << OW) - 1) ? 1 : 0;
    endfunction

    function automatic int pick(input logic [NR-1:0] mask);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
        end
        return -1;
    endfunction

    task automatic pack();
        for (int i = 0; i < NR; i++) req_din[i*IW +: IW] = din_v[i];
    endtask

    task automatic count_sat(input int din);
        if (ref_sat(din) == 1 && sat_m < 65535) sat_m++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_dout"}, 32'(resp_dout), 32'd0);
        chk({tag, "_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_sat"}, 32'(resp_sat), 32'd0);
        chk({tag, "_cnt"}, 32'(sat_count), 32'd0);
    endtask

    // One full transaction with `stall` cycles of backpressure in RESP.
    task automatic txn(input string tag, input logic [NR-1:0] mask, input int stall);
        int w;
        int d;
        w = pick(mask);
        d = int'(din_v[w]);
        @(negedge clk);
        pack();
        req_valid  = mask;
        resp_ready = 1'b1;
        #1;
        chk({tag, "_grant"}, 32'(req_ready), 32'(1 << w));
        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = (stall == 0);
        ptr_m      = (w + 1) % NR;
        count_sat(d);
        chk({tag, "_calc_valid"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_dout"}, 32'(resp_dout), 32'(ref_q(d)));
        chk({tag, "_id"}, 32'(resp_id), 32'(w));
        chk({tag, "_sat"}, 32'(resp_sat), 32'(ref_sat(d)));
        chk({tag, "_cnt"}, 32'(sat_count), 32'(sat_m));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, "_hold_dout"}, 32'(resp_dout), 32'(ref_q(d)));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int w;
        int n;
        int cnt [NR];
        rst = 1'b0; req_valid = '0; resp_ready = 1'b0; req_din = '0;
        for (int i = 0; i < NR; i++) din_v[i] = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        // Defaults and rounding
        din_v[0] = 11'd73;   txn("t1_73", 4'b0001, 0);
        din_v[2] = 11'd79;   txn("t2_79", 4'b0100, 0);
        din_v[2] = 11'd76;   txn("t2_76", 4'b0100, 1);
        din_v[2] = 11'd75;   txn("t2_75", 4'b0100, 0);
        // Saturation boundary
        din_v[2] = 11'd2043; txn("t3_2043", 4'b0100, 0);
        din_v[2] = 11'd2044; txn("t3_2044", 4'b0100, 0);
        din_v[2] = 11'd2047; txn("t3_2047", 4'b0100, 0);
        chk("t3_sat_count", 32'(sat_count), 32'd2);

        // Round robin with all requesters held from reset
        @(negedge clk);
        rst = 1'b0; ptr_m = 0; sat_m = 0;
        for (int i = 0; i < NR; i++) begin
            din_v[i] = IW'($urandom_range(0, 2047));
            cnt[i] = 0;
        end
        pack();
        req_valid = 4'b1111; resp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            chk("rr_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (resp_valid) begin
                w = ptr_m;
                ptr_m = (ptr_m + 1) % NR;
                count_sat(int'(din_v[w]));
                chk("rr_id", 32'(resp_id), 32'(w));
                chk("rr_dout", 32'(resp_dout), 32'(ref_q(int'(din_v[w]))));
                if (n < NR) cnt[resp_id]++;
                n++;
                if (n == 5) req_valid = '0;
            end
        end
        chk("rr_count", 32'(n), 32'd5);
        for (int i = 0; i < NR; i++) chk("rr_fair", 32'(cnt[i]), 32'd1);

        // Backpressure: ten stalled cycles in RESP
        din_v[1] = IW'($urandom_range(0, 2047));
        din_v[3] = IW'($urandom_range(0, 2047));
        @(negedge clk);
        pack();
        req_valid = 4'b1010; resp_ready = 1'b0;
        #1;
        w = pick(4'b1010);
        chk("bp_grant", 32'(req_ready), 32'(1 << w));
        @(posedge clk); #1;
        req_valid = 4'b1000;
        ptr_m = (w + 1) % NR;
        count_sat(int'(din_v[1]));
        @(posedge clk); #1;
        chk("bp_cnt", 32'(sat_count), 32'(sat_m));
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_dout", 32'(resp_dout), 32'(ref_q(int'(din_v[1]))));
            chk("bp_id", 32'(resp_id), 32'd1);
            chk("bp_sat", 32'(resp_sat), 32'(ref_sat(int'(din_v[1]))));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_one_resp", 32'(resp_valid), 32'd0);
        w = pick(4'b1000);
        chk("bp_next_grant", 32'(req_ready), 32'(1 << w));
        @(posedge clk); #1;
        req_valid = '0;
        ptr_m = (w + 1) % NR;
        count_sat(int'(din_v[3]));
        @(negedge clk);
        chk("bp_next_calc", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(resp_valid), 32'd1);
        chk("bp_next_id", 32'(resp_id), 32'd3);
        chk("bp_next_dout", 32'(resp_dout), 32'(ref_q(int'(din_v[3]))));

        // Async reset while in CALC, then while in RESP
        for (int pass = 0; pass < 2; pass++) begin
            din_v[2] = IW'($urandom_range(0, 2047));
            din_v[0] = IW'($urandom_range(0, 2047));
            @(negedge clk);
            pack();
            req_valid = 4'b0100; resp_ready = 1'b0;
            @(posedge clk); #1;
            req_valid = '0;
            if (pass == 1) begin
                @(posedge clk); #1;
                chk("rst_resp_pre", 32'(resp_valid), 32'd1);
            end
            #1 rst = 1'b0;
            #1 chk_reset(pass == 0 ? "rst_calc" : "rst_resp");
            ptr_m = 0; sat_m = 0;
            @(negedge clk); @(negedge clk);
            rst = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("rst_no_stale", 32'(resp_valid), 32'd0);
            end
        end
        txn("rst_next", 4'b1111, 0);

        // Randomized traffic
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NR; i++) begin
                din_v[i] = ($urandom_range(0, 1) == 1) ? IW'($urandom_range(1990, 2047))
                                                         : IW'($urandom_range(0, 2047));
            end
            txn("rand", NR'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
